// File: rtl/pool_stream_ctrl_if.sv
// Stream handshake bundle for pool_stream_ctrl: frame control, pixel input
// stream and pooled pixel output stream. The optional start-of-frame check
// signals exist only when POOL_SOF_CHECK_EN is defined.
interface pool_stream_ctrl_if #(
  parameter int PX_SIZE = 8
);
  logic               start;
  logic               busy;
  logic [PX_SIZE-1:0] in_px;
  logic               in_valid;
  logic               in_ready;
  logic [PX_SIZE-1:0] out_px;
  logic               out_valid;
  logic               out_ready;
  logic               frame_done;
`ifdef POOL_SOF_CHECK_EN
  logic               in_sof;
  logic               sof_err;

  modport master (
    output start, in_px, in_valid, out_ready, in_sof,
    input  busy, in_ready, out_px, out_valid, frame_done, sof_err
  );
  modport slave (
    input  start, in_px, in_valid, out_ready, in_sof,
    output busy, in_ready, out_px, out_valid, frame_done, sof_err
  );
`else
  modport master (
    output start, in_px, in_valid, out_ready,
    input  busy, in_ready, out_px, out_valid, frame_done
  );
  modport slave (
    input  start, in_px, in_valid, out_ready,
    output busy, in_ready, out_px, out_valid, frame_done
  );
`endif
endinterface

// File: rtl/pool_stream_ctrl.sv
// pool_stream_ctrl: raster-stream max-pool sequencer.
// Consumes INPUT_SIZE^2 pixels per frame, keeps a running max per output
// column, and emits one pooled pixel per completed KxK window (stride K).
// Optional feature macro: POOL_SOF_CHECK_EN (in_sof input, sticky sof_err).
module pool_stream_ctrl #(
  parameter int INPUT_SIZE  = 6,
  parameter int KERNEL_SIZE = 2,
  parameter int PX_SIZE     = 8
) (
  input logic            clk,
  input logic            rst_n,
  pool_stream_ctrl_if.slave io_bus
);
  localparam int OUTPUT_SIZE = INPUT_SIZE / KERNEL_SIZE;
  localparam int CROP        = OUTPUT_SIZE * KERNEL_SIZE;
  // Counter width holds INPUT_SIZE itself so KERNEL_SIZE/CROP constants fit.
  localparam int CW = $clog2(INPUT_SIZE + 1);
  localparam int OW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_row;
  logic [CW-1:0]      r_col;
  logic [PX_SIZE-1:0] r_out_px;
  logic               r_out_valid;
  logic               r_frame_done;
  logic [PX_SIZE-1:0] r_buf [OUTPUT_SIZE];

  logic               w_in_ready;
  logic               w_acc;
  logic               w_restart;
  logic [CW-1:0]      w_row;
  logic [CW-1:0]      w_col;
  logic [CW-1:0]      w_wr;
  logic [CW-1:0]      w_wc;
  logic [OW-1:0]      w_oc;
  logic               w_in_win;
  logic               w_first;
  logic               w_close;
  logic               w_last;
  logic               w_load;
  logic [PX_SIZE-1:0] w_cur;
  logic [PX_SIZE-1:0] w_max;

  // Single output register: accept a pixel only if the result slot is free
  // or is being drained this cycle.
  assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || io_bus.out_ready);
  assign w_acc      = io_bus.in_valid && w_in_ready;

`ifdef POOL_SOF_CHECK_EN
  logic r_sof_err;
  logic w_sof_bad;
  // An in_sof away from the origin resynchronises the position to (0,0);
  // any disagreement between in_sof and the origin is flagged.
  assign w_restart = io_bus.in_sof && ((r_row != '0) || (r_col != '0));
  assign w_sof_bad = w_acc && (io_bus.in_sof != ((r_row == '0) && (r_col == '0)));
  assign io_bus.sof_err = r_sof_err;
`else
  assign w_restart = 1'b0;
`endif

  // Effective position of the current pixel and its place in the window.
  assign w_row    = w_restart ? '0 : r_row;
  assign w_col    = w_restart ? '0 : r_col;
  assign w_wr     = w_row % CW'(KERNEL_SIZE);
  assign w_wc     = w_col % CW'(KERNEL_SIZE);
  assign w_oc     = OW'(w_col / CW'(KERNEL_SIZE));
  assign w_in_win = (w_row < CW'(CROP)) && (w_col < CW'(CROP));
  assign w_first  = (w_wr == '0) && (w_wc == '0);
  assign w_close  = (w_wr == CW'(KERNEL_SIZE - 1)) && (w_wc == CW'(KERNEL_SIZE - 1));
  assign w_last   = (w_row == CW'(INPUT_SIZE - 1)) && (w_col == CW'(INPUT_SIZE - 1));
  assign w_load   = w_acc && w_in_win && w_close;
  assign w_cur    = r_buf[w_oc];
  assign w_max    = (io_bus.in_px > w_cur) ? io_bus.in_px : w_cur;

  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.busy       = (r_state != S_IDLE);
  assign io_bus.out_px     = r_out_px;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.frame_done = r_frame_done;

  // Frame FSM, raster counters and the pooled-pixel output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_out_px     <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef POOL_SOF_CHECK_EN
      r_sof_err    <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      // A load wins over a drain so both can happen in one cycle.
      if (w_load) begin
        r_out_px    <= w_max;
        r_out_valid <= 1'b1;
      end else if (io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_state <= S_RUN;
            r_row   <= '0;
            r_col   <= '0;
`ifdef POOL_SOF_CHECK_EN
            r_sof_err <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (w_acc) begin
            if (w_col == CW'(INPUT_SIZE - 1)) begin
              r_col <= '0;
              r_row <= (w_row == CW'(INPUT_SIZE - 1)) ? '0 : w_row + CW'(1);
            end else begin
              r_col <= w_col + CW'(1);
              r_row <= w_row;
            end
            if (w_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // With cropping the final result may already be gone by now.
          if (!r_out_valid || io_bus.out_ready) begin
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef POOL_SOF_CHECK_EN
      if (w_sof_bad) r_sof_err <= 1'b1;
`endif
    end
  end

  // Running max per output column; a window start overwrites the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) r_buf[i] <= '0;
    end else if (w_acc && w_in_win) begin
      r_buf[w_oc] <= w_first ? io_bus.in_px : w_max;
    end
  end

endmodule

// File: tb/tb_pool_stream_ctrl.sv
// Self-checking bench for pool_stream_ctrl: a 4x4 and a 5x5 (crop) instance,
// expected pooled pixels queued on stimulus and popped by an output monitor.
module tb_pool_stream_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pool_stream_ctrl_if #(.PX_SIZE(8)) if4 ();
  pool_stream_ctrl_if #(.PX_SIZE(8)) if5 ();

  pool_stream_ctrl #(.INPUT_SIZE(4), .KERNEL_SIZE(2), .PX_SIZE(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .io_bus(if4.slave));
  pool_stream_ctrl #(.INPUT_SIZE(5), .KERNEL_SIZE(2), .PX_SIZE(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .io_bus(if5.slave));

  int         checks   = 0;
  int         failures = 0;
  int         sof_idx  = -1;
  logic [7:0] exp_q [$];
  logic [7:0] stim  [$];
  logic [7:0] mon_exp;

  // Output monitor: every handshake pops one expected pooled pixel.
  always @(negedge clk) begin
    if (rst_n && if4.out_valid && if4.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out4_unexpected got=%0h required=none", if4.out_px);
      end else begin
        mon_exp = exp_q.pop_front();
        if (if4.out_px !== mon_exp) begin
          failures++;
          $display("FAIL out4_px got=%0h required=%0h", if4.out_px, mon_exp);
        end
      end
    end
    if (rst_n && if5.out_valid && if5.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out5_unexpected got=%0h required=none", if5.out_px);
      end else begin
        mon_exp = exp_q.pop_front();
        if (if5.out_px !== mon_exp) begin
          failures++;
          $display("FAIL out5_px got=%0h required=%0h", if5.out_px, mon_exp);
        end
      end
    end
  end

  // Reference max-pool over stim (K=2), pushed in raster order.
  task automatic push_model(input int n);
    int o;
    logic [7:0] m, v;
    o = n / 2;
    for (int orow = 0; orow < o; orow++)
      for (int ocol = 0; ocol < o; ocol++) begin
        m = 8'h00;
        for (int kr = 0; kr < 2; kr++)
          for (int kc = 0; kc < 2; kc++) begin
            v = stim[(orow*2 + kr)*n + ocol*2 + kc];
            if (v > m) m = v;
          end
        exp_q.push_back(m);
      end
  endtask

  task automatic push4(input logic [7:0] a, b, c, d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask

  // Start a frame, stream stim, optionally stall the output for stall_len
  // cycles after the first out_valid, then wait for frame_done.
  // lat = edges between the last pixel acceptance and frame_done.
  task automatic run(virtual pool_stream_ctrl_if #(.PX_SIZE(8)) vif,
                     input int stall_len, input logic [7:0] hold_exp,
                     output int lat);
    int idx, cyc, stall_left;
    bit seen, acc;
    idx = 0; cyc = 0; stall_left = 0; seen = 0; lat = -1;
    @(posedge clk); #1;
    checks++;
    if (vif.busy !== 1'b0) begin
      failures++; $display("FAIL busy_before_start got=%b required=0", vif.busy);
    end
    vif.start = 1'b1;
    @(posedge clk); #1;
    vif.start = 1'b0;
    checks++;
    if (vif.busy !== 1'b1) begin
      failures++; $display("FAIL busy_after_start got=%b required=1", vif.busy);
    end
    vif.out_ready = 1'b1;
    vif.in_valid  = 1'b1;
    vif.in_px     = stim[0];
`ifdef POOL_SOF_CHECK_EN
    vif.in_sof    = 1'b1;
`endif
    while (idx < stim.size() && cyc < 1000) begin
      @(negedge clk);
      acc = vif.in_valid && vif.in_ready;
      if (seen && stall_left > 0) begin
        checks++;
        if (vif.in_ready !== 1'b0 || vif.out_px !== hold_exp || vif.out_valid !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold got in_ready=%b out_valid=%b out_px=%0h required 0/1/%0h",
                   vif.in_ready, vif.out_valid, vif.out_px, hold_exp);
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < stim.size()) vif.in_px = stim[idx];
        else vif.in_valid = 1'b0;
`ifdef POOL_SOF_CHECK_EN
        vif.in_sof = (idx == sof_idx);
`endif
      end
      if (stall_left > 0) stall_left--;
      if (stall_len > 0 && !seen && vif.out_valid) begin
        seen = 1'b1;
        stall_left = stall_len;
      end
      vif.out_ready = (stall_left == 0);
    end
    checks++;
    if (idx != stim.size()) begin
      failures++; $display("FAIL input_timeout got=%0d required=%0d", idx, stim.size());
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (vif.frame_done === 1'b1) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat < 0) begin
      failures++; $display("FAIL frame_done_timeout got=none required=pulse");
    end
    checks++;
    if (exp_q.size() != 0 || vif.busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_end got pending=%0d busy=%b required 0/0", exp_q.size(), vif.busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (if4.busy !== 1'b0 || if4.in_ready !== 1'b0 || if4.out_valid !== 1'b0 ||
        if4.out_px !== 8'h00 || if4.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset4 got busy=%b in_ready=%b out_valid=%b out_px=%0h done=%b required all 0",
               if4.busy, if4.in_ready, if4.out_valid, if4.out_px, if4.frame_done);
    end
    checks++;
    if (if5.busy !== 1'b0 || if5.out_valid !== 1'b0 || if5.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset5 got busy=%b out_valid=%b done=%b required 0", if5.busy, if5.out_valid, if5.frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // in_valid with the FSM idle must not be accepted
    @(posedge clk); #1;
    if4.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (if4.in_ready !== 1'b0 || if4.busy !== 1'b0) begin
      failures++; $display("FAIL idle_in_ready got=%b required=0", if4.in_ready);
    end
    if4.in_valid = 1'b0;
  endtask

  task automatic fill_ramp(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'(i));
  endtask

  task automatic test_basic();
    int lat;
    fill_ramp(16);
    push4(8'd5, 8'd7, 8'd13, 8'd15);
    run(if4, 0, 8'h00, lat);
    checks++;
    if (lat != 1) begin
      failures++; $display("FAIL basic_done_latency got=%0d required=1", lat);
    end
`ifdef POOL_SOF_CHECK_EN
    checks++;
    if (if4.sof_err !== 1'b0) begin
      failures++; $display("FAIL sof_err_clean got=%b required=0", if4.sof_err);
    end
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    fill_ramp(16);
    push4(8'd5, 8'd7, 8'd13, 8'd15);
    run(if4, 5, 8'd5, lat);
  endtask

  task automatic test_crop();
    int lat;
    fill_ramp(25);
    push4(8'd6, 8'd8, 8'd16, 8'd18);
    run(if5, 0, 8'h00, lat);
    checks++;
    if (lat != 1) begin
      failures++; $display("FAIL crop_done_latency got=%0d required=1", lat);
    end
  endtask

  task automatic test_unsigned_ties();
    int lat, r, c;
    stim.delete();
    // one zero per window, at a different window position each time
    for (int p = 0; p < 16; p++) begin
      r = p / 4; c = p % 4;
      stim.push_back((((r/2)*2 + c/2) == ((r%2)*2 + c%2)) ? 8'h00 : 8'hFF);
    end
    push4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run(if4, 0, 8'h00, lat);
    stim.delete();
    for (int p = 0; p < 16; p++) stim.push_back(8'h80);
    push4(8'h80, 8'h80, 8'h80, 8'h80);
    run(if4, 0, 8'h00, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int f = 0; f < 3; f++) begin
      stim.delete();
      for (int p = 0; p < 16; p++) stim.push_back(8'($urandom_range(0, 255)));
      push_model(4);
      run(if4, (f == 1) ? 3 : 0, exp_q[0], lat);
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc_n, cyc, lat;
    bit a;
    acc_n = 0; cyc = 0;
    @(posedge clk); #1;
    if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start     = 1'b0;
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    if4.in_px     = 8'd0;
    while (acc_n < 6 && cyc < 100) begin
      @(negedge clk);
      a = if4.in_valid && if4.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (a) begin
        acc_n++;
        if4.in_px = 8'(acc_n);
      end
    end
    checks++;
    if (acc_n != 6 || if4.out_valid !== 1'b1 || if4.busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got acc=%0d out_valid=%b busy=%b required 6/1/1", acc_n, if4.out_valid, if4.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (if4.busy !== 1'b0 || if4.out_valid !== 1'b0 || if4.frame_done !== 1'b0 || if4.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got busy=%b out_valid=%b done=%b in_ready=%b required 0",
               if4.busy, if4.out_valid, if4.frame_done, if4.in_ready);
    end
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fill_ramp(16);
    push4(8'd5, 8'd7, 8'd13, 8'd15);
    run(if4, 0, 8'h00, lat);
  endtask

`ifdef POOL_SOF_CHECK_EN
  task automatic test_sof();
    int lat;
    stim.delete();
    stim.push_back(8'd200);
    stim.push_back(8'd201);
    for (int i = 0; i < 16; i++) stim.push_back(8'(i));
    sof_idx = 2;
    push4(8'd5, 8'd7, 8'd13, 8'd15);
    run(if4, 0, 8'h00, lat);
    sof_idx = -1;
    checks++;
    if (if4.sof_err !== 1'b1) begin
      failures++; $display("FAIL sof_err got=%b required=1", if4.sof_err);
    end
  endtask
`endif

  initial begin
    if4.start = 1'b0; if4.in_valid = 1'b0; if4.in_px = 8'h00; if4.out_ready = 1'b0;
    if5.start = 1'b0; if5.in_valid = 1'b0; if5.in_px = 8'h00; if5.out_ready = 1'b0;
`ifdef POOL_SOF_CHECK_EN
    if4.in_sof = 1'b0; if5.in_sof = 1'b0;
`endif
    test_reset();
    test_basic();
    test_backpressure();
    test_crop();
    test_unsigned_ties();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef POOL_SOF_CHECK_EN
    test_sof();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
